// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz scan geometry and shared helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 32;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(coord_t v, int unsigned lo, int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pixel_tick.sv
// Pixel-rate enable: divides the system clock by CLK_DIV, pulsing pix_en on the last cycle of each pixel.
module pixel_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // With CLK_DIV == 1 the divider sits at zero and pix_en stays high.
  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing.sv
// VGA scan timing: pixel/line counters with sync, blank and frame markers registered
// from the next coordinate so every output describes the same pixel.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               vnotactive,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_en,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  coord_t     col_q, col_d;
  coord_t     row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vnotactive_q, vnotactive_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .clk   (CLK),
    .rst   (RST),
    .pix_en(pix_en)
  );

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      if (col_q == H_TOTAL - 1) begin
        col_d = '0;
        if (row_q == V_TOTAL - 1) begin
          row_d         = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          row_d = row_q + coord_t'(1);
        end
      end else begin
        col_d = col_q + coord_t'(1);
      end
    end
    // Decoded from the next coordinate so the registered flags line up with col/row.
    hsync_d      = !in_window(col_d, HS_START, HS_END);
    vsync_d      = !in_window(row_d, VS_START, VS_END);
    vnotactive_d = (col_d >= H_ACTIVE) || (row_d >= V_ACTIVE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vnotactive_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vnotactive_q  <= vnotactive_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vnotactive  = vnotactive_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three geometries checked cycle by cycle against an arithmetic
// model that derives every output from the elapsed cycle count since reset release.
module tb_vga_timing;

  typedef struct packed {
    logic [31:0] col;
    logic [31:0] row;
    logic        hs;
    logic        vs;
    logic        vna;
    logic        pe;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct packed {
    int unsigned div;
    int unsigned ha;
    int unsigned hfp;
    int unsigned hsw;
    int unsigned hbp;
    int unsigned va;
    int unsigned vfp;
    int unsigned vsw;
    int unsigned vbp;
  } geom_t;

  localparam geom_t G_DEF = '{div:2, ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33};
  localparam geom_t G_S   = '{div:2, ha:20,  hfp:3,  hsw:5,  hbp:4,  va:12,  vfp:2,  vsw:2, vbp:3};
  localparam geom_t G_1   = '{div:1, ha:8,   hfp:2,  hsw:3,  hbp:2,  va:6,   vfp:1,  vsw:2, vbp:1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] def_col, def_row, s_col, s_row, o1_col, o1_row;
  logic def_vna, def_hs, def_vs, def_pe, def_fs;
  logic s_vna, s_hs, s_vs, s_pe, s_fs;
  logic o1_vna, o1_hs, o1_vs, o1_pe, o1_fs;
  logic [7:0] def_fc, s_fc, o1_fc;

  obs_t o_def, o_s, o_1;
  assign o_def = {def_col, def_row, def_hs, def_vs, def_vna, def_pe, def_fs, def_fc};
  assign o_s   = {s_col, s_row, s_hs, s_vs, s_vna, s_pe, s_fs, s_fc};
  assign o_1   = {o1_col, o1_row, o1_hs, o1_vs, o1_vna, o1_pe, o1_fs, o1_fc};

  always #5 clk = ~clk;

  vga_timing #(
    .CLK_DIV(G_DEF.div), .H_ACTIVE(G_DEF.ha), .H_FP(G_DEF.hfp), .H_SYNC(G_DEF.hsw), .H_BP(G_DEF.hbp),
    .V_ACTIVE(G_DEF.va), .V_FP(G_DEF.vfp), .V_SYNC(G_DEF.vsw), .V_BP(G_DEF.vbp)
  ) u_def (
    .CLK(clk), .RST(rst), .col(def_col), .row(def_row), .vnotactive(def_vna), .hsync(def_hs),
    .vsync(def_vs), .pix_en(def_pe), .frame_start(def_fs), .frame_count(def_fc)
  );

  vga_timing #(
    .CLK_DIV(G_S.div), .H_ACTIVE(G_S.ha), .H_FP(G_S.hfp), .H_SYNC(G_S.hsw), .H_BP(G_S.hbp),
    .V_ACTIVE(G_S.va), .V_FP(G_S.vfp), .V_SYNC(G_S.vsw), .V_BP(G_S.vbp)
  ) u_small (
    .CLK(clk), .RST(rst), .col(s_col), .row(s_row), .vnotactive(s_vna), .hsync(s_hs),
    .vsync(s_vs), .pix_en(s_pe), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing #(
    .CLK_DIV(G_1.div), .H_ACTIVE(G_1.ha), .H_FP(G_1.hfp), .H_SYNC(G_1.hsw), .H_BP(G_1.hbp),
    .V_ACTIVE(G_1.va), .V_FP(G_1.vfp), .V_SYNC(G_1.vsw), .V_BP(G_1.vbp)
  ) u_div1 (
    .CLK(clk), .RST(rst), .col(o1_col), .row(o1_row), .vnotactive(o1_vna), .hsync(o1_hs),
    .vsync(o1_vs), .pix_en(o1_pe), .frame_start(o1_fs), .frame_count(o1_fc)
  );

  int unsigned t;
  int checks = 0;
  int fails  = 0;

  function automatic int unsigned h_total(geom_t g);
    return g.ha + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int unsigned frame_clks(geom_t g);
    return h_total(g) * (g.va + g.vfp + g.vsw + g.vbp) * g.div;
  endfunction

  // Everything follows from pixel index p = tt / div and the phase within that pixel.
  function automatic obs_t model(int unsigned tt, geom_t g);
    int unsigned ht, vt, fpix, p, ph, c, r;
    obs_t e;
    ht   = h_total(g);
    vt   = g.va + g.vfp + g.vsw + g.vbp;
    fpix = ht * vt;
    p    = tt / g.div;
    ph   = tt % g.div;
    c    = p % ht;
    r    = (p / ht) % vt;
    e.col = c;
    e.row = r;
    e.hs  = !((c >= g.ha + g.hfp) && (c < g.ha + g.hfp + g.hsw));
    e.vs  = !((r >= g.va + g.vfp) && (r < g.va + g.vfp + g.vsw));
    e.vna = (c >= g.ha) || (r >= g.va);
    e.pe  = (ph == g.div - 1);
    e.fs  = (ph == 0) && (p != 0) && (p % fpix == 0);
    e.fc  = 8'((p / fpix) % 256);
    return e;
  endfunction

  function automatic string show(obs_t o);
    return $sformatf("col=%0d row=%0d hs=%b vs=%b vna=%b pe=%b fs=%b fc=%0d",
                     o.col, o.row, o.hs, o.vs, o.vna, o.pe, o.fs, o.fc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset(int unsigned width);
    rst = 1'b1;
    repeat (width) tick();
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    obs_t r2, r1;
    r2 = '{col:32'd0, row:32'd0, hs:1'b1, vs:1'b1, vna:1'b0, pe:1'b0, fs:1'b0, fc:8'd0};
    r1 = r2;
    r1.pe = 1'b1;
    do_reset(1);
    repeat ($urandom_range(500, 20)) tick();
    do_reset($urandom_range(3, 1));
    checks++;
    if (o_def !== r2) begin fails++; $display("FAIL reset_def got %s exp %s", show(o_def), show(r2)); end
    checks++;
    if (o_s !== r2) begin fails++; $display("FAIL reset_small got %s exp %s", show(o_s), show(r2)); end
    checks++;
    if (o_1 !== r1) begin fails++; $display("FAIL reset_div1 got %s exp %s", show(o_1), show(r1)); end
  endtask

  task automatic test_first_pixels();
    obs_t e;
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      e = model(t, G_DEF);
      checks++;
      if (o_def !== e) begin
        fails++;
        $display("FAIL first_pixels t=%0d got %s exp %s", t, show(o_def), show(e));
        break;
      end
      tick();
    end
  endtask

  task automatic test_line();
    obs_t e;
    int unsigned hs_low, vna_hi;
    hs_low = 0;
    vna_hi = 0;
    do_reset(1);
    for (int i = 0; i < 1700; i++) begin
      e = model(t, G_DEF);
      checks++;
      if (o_def !== e) begin
        fails++;
        $display("FAIL line t=%0d got %s exp %s", t, show(o_def), show(e));
        break;
      end
      if (t == h_total(G_DEF) * G_DEF.div) begin
        checks++;
        if (o_def.col !== 32'd0 || o_def.row !== 32'd1) begin
          fails++;
          $display("FAIL line_wrap got col=%0d row=%0d exp col=0 row=1", o_def.col, o_def.row);
        end
      end
      if (t < h_total(G_DEF) * G_DEF.div) begin
        if (!o_def.hs) hs_low++;
        if (o_def.vna) vna_hi++;
      end
      tick();
    end
    checks++;
    if (hs_low != G_DEF.hsw * G_DEF.div) begin
      fails++;
      $display("FAIL hsync_width got %0d exp %0d", hs_low, G_DEF.hsw * G_DEF.div);
    end
    checks++;
    if (vna_hi != (h_total(G_DEF) - G_DEF.ha) * G_DEF.div) begin
      fails++;
      $display("FAIL hblank_width got %0d exp %0d", vna_hi, (h_total(G_DEF) - G_DEF.ha) * G_DEF.div);
    end
  endtask

  task automatic test_frame();
    obs_t e;
    int unsigned fs_cnt, fs_t, vs_low;
    fs_cnt = 0;
    fs_t   = 0;
    vs_low = 0;
    do_reset(1);
    for (int i = 0; i < int'(frame_clks(G_S)) + 40; i++) begin
      e = model(t, G_S);
      checks++;
      if (o_s !== e) begin
        fails++;
        $display("FAIL frame t=%0d got %s exp %s", t, show(o_s), show(e));
        break;
      end
      if (o_s.fs) begin fs_cnt++; fs_t = t; end
      if (!o_s.vs) vs_low++;
      tick();
    end
    checks++;
    if (fs_cnt != 1 || fs_t != frame_clks(G_S)) begin
      fails++;
      $display("FAIL frame_start got count=%0d at=%0d exp count=1 at=%0d", fs_cnt, fs_t, frame_clks(G_S));
    end
    checks++;
    if (vs_low != G_S.vsw * h_total(G_S) * G_S.div) begin
      fails++;
      $display("FAIL vsync_width got %0d exp %0d", vs_low, G_S.vsw * h_total(G_S) * G_S.div);
    end
    checks++;
    if (o_s.fc !== 8'd1) begin fails++; $display("FAIL frame_count got %0d exp 1", o_s.fc); end
  endtask

  task automatic test_mid_reset();
    obs_t e, r2;
    int unsigned n_list[4];
    int unsigned fs_cnt;
    r2 = '{col:32'd0, row:32'd0, hs:1'b1, vs:1'b1, vna:1'b0, pe:1'b0, fs:1'b0, fc:8'd0};
    n_list[0] = $urandom_range(2400, 100);
    n_list[1] = $urandom_range(2400, 100);
    n_list[2] = (8 * h_total(G_S) + 12) * G_S.div;
    n_list[3] = frame_clks(G_S) - 1;
    foreach (n_list[k]) begin
      do_reset(1);
      for (int unsigned i = 0; i < n_list[k]; i++) tick();
      e = model(t, G_S);
      checks++;
      if (o_s !== e) begin fails++; $display("FAIL pre_reset t=%0d got %s exp %s", t, show(o_s), show(e)); end
      rst = 1'b1;
      tick();
      checks++;
      if (o_s !== r2) begin fails++; $display("FAIL mid_reset n=%0d got %s exp %s", n_list[k], show(o_s), show(r2)); end
      rst = 1'b0;
      t = 0;
      fs_cnt = 0;
      for (int unsigned i = 0; i <= frame_clks(G_S) + 3; i++) begin
        e = model(t, G_S);
        checks++;
        if (o_s !== e) begin
          fails++;
          $display("FAIL post_reset t=%0d got %s exp %s", t, show(o_s), show(e));
          break;
        end
        if (o_s.fs) fs_cnt++;
        tick();
      end
      checks++;
      if (fs_cnt != 1 || o_s.fc !== 8'd1) begin
        fails++;
        $display("FAIL post_reset_frame got pulses=%0d fc=%0d exp pulses=1 fc=1", fs_cnt, o_s.fc);
      end
    end
  endtask

  task automatic test_div1_wrap();
    obs_t e;
    int unsigned fs_cnt, pe_low, fclk;
    fs_cnt = 0;
    pe_low = 0;
    fclk   = frame_clks(G_1);
    do_reset(1);
    for (int unsigned i = 0; i <= 256 * fclk + 3; i++) begin
      e = model(t, G_1);
      checks++;
      if (o_1 !== e) begin
        fails++;
        $display("FAIL div1 t=%0d got %s exp %s", t, show(o_1), show(e));
        break;
      end
      if (!o_1.pe) pe_low++;
      if (o_1.fs) fs_cnt++;
      if (t == 255 * fclk) begin
        checks++;
        if (o_1.fc !== 8'd255) begin fails++; $display("FAIL fc_255 got %0d exp 255", o_1.fc); end
      end
      if (t == 256 * fclk) begin
        checks++;
        if (o_1.fc !== 8'd0 || o_1.fs !== 1'b1) begin
          fails++;
          $display("FAIL fc_wrap got fc=%0d fs=%b exp fc=0 fs=1", o_1.fc, o_1.fs);
        end
      end
      tick();
    end
    checks++;
    if (pe_low != 0) begin fails++; $display("FAIL div1_pix_en got low_cycles=%0d exp 0", pe_low); end
    checks++;
    if (fs_cnt != 256) begin fails++; $display("FAIL div1_frames got %0d exp 256", fs_cnt); end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    for (int k = 0; k < 6; k++) begin
      do_reset($urandom_range(3, 1));
      repeat ($urandom_range(40, 1)) begin
        e = model(t, G_S);
        checks++;
        if (o_s !== e) begin fails++; $display("FAIL b2b_small t=%0d got %s exp %s", t, show(o_s), show(e)); end
        e = model(t, G_1);
        checks++;
        if (o_1 !== e) begin fails++; $display("FAIL b2b_div1 t=%0d got %s exp %s", t, show(o_1), show(e)); end
        e = model(t, G_DEF);
        checks++;
        if (o_def !== e) begin fails++; $display("FAIL b2b_def t=%0d got %s exp %s", t, show(o_def), show(e)); end
        tick();
      end
    end
  endtask

  initial begin
    t = 0;
    test_reset();
    test_first_pixels();
    test_line();
    test_frame();
    test_mid_reset();
    test_div1_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
